// File: rtl/alu_operand_seq.sv
// Operand/opcode entry sequencer: a debounced pushbutton steps through A, B and opcode capture, then issues a valid/ready request.
// Optional debounce filter enabled by defining ALU_OPERAND_SEQ_DEBOUNCE_EN.
module alu_operand_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [9:0]  SW,
  input  logic        key_n,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [4:0]  alu_op,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [1:0]  state,
  output logic [7:0]  issue_cnt
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    ISSUE   = 2'd3
  } state_t;

  state_t     cur;
  logic       sync1, sync2;
  logic [1:0] fill;
  logic       level, level_prev, armed, press;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      fill  <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

`ifdef ALU_OPERAND_SEQ_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] db_cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples differing from it.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      level  <= 1'b1;
      db_cnt <= RELOAD;
    end else if (sync2 == level) begin
      db_cnt <= RELOAD;
    end else if (db_cnt == '0) begin
      level  <= sync2;
      db_cnt <= RELOAD;
    end else begin
      db_cnt <= db_cnt - 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign level      = sync2;
`endif

  // Pulses stay blocked after reset until the key has been seen released once the synchronizer has filled.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      level_prev <= 1'b1;
      armed      <= 1'b0;
    end else begin
      level_prev <= level;
      if (fill[1] && sync2 && level) armed <= 1'b1;
    end
  end

  assign press = armed & level_prev & ~level;

  function automatic logic [4:0] op_code(input logic [2:0] sel);
    logic [4:0] code;
    case (sel)
      3'b000:  code = 5'd0;
      3'b001:  code = 5'd8;
      3'b010:  code = 5'd14;
      3'b011:  code = 5'd16;
      3'b100:  code = 5'd18;
      3'b101:  code = 5'd20;
      3'b110:  code = 5'd21;
      default: code = 5'd23;
    endcase
    return code;
  endfunction

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cur       <= LOAD_A;
      a         <= '0;
      b         <= '0;
      alu_op    <= '0;
      op_valid  <= 1'b0;
      issue_cnt <= '0;
    end else begin
      case (cur)
        LOAD_A: if (press) begin
          a   <= {{6{SW[9]}}, SW};
          cur <= LOAD_B;
        end
        LOAD_B: if (press) begin
          b   <= {{6{SW[9]}}, SW};
          cur <= LOAD_OP;
        end
        LOAD_OP: if (press) begin
          alu_op   <= op_code(SW[2:0]);
          op_valid <= 1'b1;
          cur      <= ISSUE;
        end
        ISSUE: if (op_valid && op_ready) begin
          op_valid  <= 1'b0;
          issue_cnt <= issue_cnt + 8'd1;
          cur       <= LOAD_A;
        end
        default: cur <= LOAD_A;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Self-checking bench for alu_operand_seq against a transaction-level model of key presses.
module tb_alu_operand_seq;

  localparam int unsigned DEB_N = 4;
`ifdef ALU_OPERAND_SEQ_DEBOUNCE_EN
  localparam int MIN_LOW = DEB_N;
`else
  localparam int MIN_LOW = 1;
`endif

  logic        CLOCK_50;
  logic        reset_n;
  logic [9:0]  SW;
  logic        key_n;
  logic [15:0] a, b;
  logic [4:0]  alu_op;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  state;
  logic [7:0]  issue_cnt;

  alu_operand_seq #(.DEBOUNCE_CYCLES(DEB_N)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .SW       (SW),
    .key_n    (key_n),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .state    (state),
    .issue_cnt(issue_cnt)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;

  // Model: which entry step we are on, captured values, and transfer count.
  int          m_phase;
  logic [15:0] m_a, m_b;
  logic [4:0]  m_op;
  int          m_cnt;
  int          valid_seen;
  int          opmap [8] = '{0, 8, 14, 16, 18, 20, 21, 23};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"},     16'(state),     16'(m_phase));
    chk({tag, ".a"},         a,              m_a);
    chk({tag, ".b"},         b,              m_b);
    chk({tag, ".alu_op"},    16'(alu_op),    16'(m_op));
    chk({tag, ".op_valid"},  16'(op_valid),  16'(m_phase == 3));
    chk({tag, ".issue_cnt"}, 16'(issue_cnt), 16'(m_cnt));
  endtask

  task automatic model_reset();
    m_phase = 0; m_a = '0; m_b = '0; m_op = '0; m_cnt = 0;
  endtask

  function automatic logic [15:0] sext(input logic [9:0] sw);
    int v;
    v = int'(sw);
    if (v >= 512) v = v - 1024;
    return 16'(v);
  endfunction

  task automatic model_transfer();
    m_cnt   = (m_cnt + 1) % 256;
    m_phase = 0;
  endtask

  task automatic model_press(input logic [9:0] sw, input int low);
    if (low >= MIN_LOW) begin
      case (m_phase)
        0: begin m_a  = sext(sw);           m_phase = 1; end
        1: begin m_b  = sext(sw);           m_phase = 2; end
        2: begin m_op = 5'(opmap[sw[2:0]]); m_phase = 3; end
        default: ;
      endcase
    end
    if (m_phase == 3 && op_ready) model_transfer();
  endtask

  task automatic press(input logic [9:0] sw, input int low);
    SW    = sw;
    key_n = 1'b0;
    repeat (low) begin
      @(negedge CLOCK_50);
      if (op_valid) valid_seen++;
    end
    key_n = 1'b1;
    repeat (12) begin
      @(negedge CLOCK_50);
      if (op_valid) valid_seen++;
    end
    model_press(sw, low);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    logic [9:0] sw;
    reset_n = 1'b0; key_n = 1'b1; SW = '0; op_ready = 1'b0;
    model_reset();
    #1;
    chk_all("reset");
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Basic transaction with immediate acceptance.
    op_ready = 1'b1;
    press(10'h3FF, 10);
    chk_all("t1a");
    chk("t1a.const", a, 16'hFFFF);
    press(10'h010, 10);
    chk_all("t1b");
    chk("t1b.const", b, 16'h0010);
    valid_seen = 0;
    press(10'h001, 10);
    chk_all("t1op");
    chk("t1.alu_op8", 16'(alu_op), 16'd8);
    chk("t1.cnt1", 16'(issue_cnt), 16'd1);
    chk("t1.valid_cycles", 16'(valid_seen), 16'd1);

    // Short glitch, long hold, then a single-cycle low.
    op_ready = 1'b0;
    press(10'($urandom), 2);
    chk_all("glitch2");
    press(10'($urandom), 10);
    chk_all("hold10");
    sw = 10'($urandom);
    SW = sw;
    key_n = 1'b0;
    @(negedge CLOCK_50);
    key_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    model_press(sw, 1);
    chk_all("single3");
    repeat (12) @(negedge CLOCK_50);

    // Stall in ISSUE: SW activity and presses must not disturb the request.
    while (m_phase != 3) press(10'($urandom), 10);
    chk_all("issue_entry");
    for (int i = 0; i < 20; i++) begin
      SW = 10'($urandom);
      @(negedge CLOCK_50);
      chk("stall.valid", 16'(op_valid), 16'd1);
      chk("stall.state", 16'(state), 16'd3);
    end
    press(10'($urandom), 10);
    chk_all("stall.press");
    op_ready = 1'b1;
    @(negedge CLOCK_50);
    model_transfer();
    chk_all("stall.xfer");

    // Run until the transfer count wraps.
    while (m_cnt != 0) begin
      for (int k = 0; k < 3; k++) press(10'($urandom), 10);
      chk_all("txn");
    end
    chk("wrap.cnt0", 16'(issue_cnt), 16'h0000);

    // Reset mid-entry with the key held down.
    op_ready = 1'b0;
    press(10'($urandom_range(1, 1023)), 10);
    press(10'($urandom_range(1, 1023)), 10);
    chk_all("pre_rst");
    key_n = 1'b0;
    @(negedge CLOCK_50);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("rst.async");
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    chk_all("rst.held");
    key_n = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    chk_all("rst.released");
    op_ready = 1'b1;
    for (int k = 0; k < 3; k++) press(10'($urandom), 10);
    chk_all("rst.txn");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
